// File: rtl/avmm_pio_gpio.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, synchronised inputs,
// edge capture with write-1-to-clear and a level interrupt. Define PIO_BOTH_EDGE_EN to capture falling edges too.
`timescale 1ns/1ps
module avmm_pio_gpio #(
  parameter int                 DATA_W    = 24,
  parameter logic [DATA_W-1:0]  RESET_OUT = '0,
  parameter logic [DATA_W-1:0]  RESET_DIR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] oe_port,
  output logic              irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_dir;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_edge;
  logic [DATA_W-1:0] r_in_p0;
  logic [DATA_W-1:0] r_in_p1;
  logic [DATA_W-1:0] r_prev;
  logic [1:0]        r_arm;
  logic              r_irq;
  logic [31:0]       r_rdata;

  logic              w_wr;
  logic              w_rd;
  logic              w_armed;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_det;
  logic [DATA_W-1:0] w_cap;
  logic [DATA_W-1:0] w_w1c;
  logic [DATA_W-1:0] w_pins;
  logic [31:0]       w_rd_mux;
  logic              w_unused_wdata;

  function automatic logic [31:0] zext(input logic [DATA_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  assign w_wr           = chipselect & ~write_n;
  assign w_rd           = chipselect & read;
  assign w_wdata        = writedata[DATA_W-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_armed        = (r_arm == 2'd3);

`ifdef PIO_BOTH_EDGE_EN
  assign w_det = r_in_p1 ^ r_prev;
`else
  assign w_det = r_in_p1 & ~r_prev;
`endif

  // Output-direction bits never capture; the arming counter hides the reset-release transient.
  assign w_cap  = w_armed ? (w_det & ~r_dir) : '0;
  assign w_w1c  = (w_wr && address == A_EDGE) ? w_wdata : '0;
  assign w_pins = (r_dir & r_out) | (~r_dir & r_in_p1);

  always_comb begin
    w_rd_mux = '0;
    case (address)
      A_DATA:  w_rd_mux = zext(w_pins);
      A_DIR:   w_rd_mux = zext(r_dir);
      A_MASK:  w_rd_mux = zext(r_mask);
      A_EDGE:  w_rd_mux = zext(r_edge);
      default: w_rd_mux = '0;
    endcase
  end

  // Stage p0/p1: two-flop synchroniser, then the previous-sample register for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_p0 <= '0;
      r_in_p1 <= '0;
      r_prev  <= '0;
      r_arm   <= 2'd0;
    end else begin
      r_in_p0 <= in_port;
      r_in_p1 <= r_in_p0;
      r_prev  <= r_in_p1;
      if (!w_armed)
        r_arm <= r_arm + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= RESET_OUT;
      r_dir  <= RESET_DIR;
      r_mask <= '0;
    end else if (w_wr) begin
      case (address)
        A_DATA:  r_out  <= w_wdata;
        A_DIR:   r_dir  <= w_wdata;
        A_MASK:  r_mask <= w_wdata;
        A_SET:   r_out  <= r_out | w_wdata;
        A_CLR:   r_out  <= r_out & ~w_wdata;
        default: ;
      endcase
    end
  end

  // A detection coinciding with a clear of the same bit keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_edge <= (r_edge & ~w_w1c) | w_cap;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rdata <= '0;
    else if (w_rd)
      r_rdata <= w_rd_mux;
  end

  assign readdata = r_rdata;
  assign out_port = r_out;
  assign oe_port  = r_dir;
  assign irq      = r_irq;

endmodule
